// File: rtl/switch_debounce.sv
// switch_debounce: synchronizes and debounces the raw board switches feeding
// the adder/carry-latch logic. Each channel owns a two-flop synchronizer bit,
// a stability counter, a registered debounced level and one-cycle rise/fall
// pulses. Channels are fully independent.
module switch_debounce #(
    parameter int unsigned NUM_IN        = 3,
    parameter int unsigned STABLE_CYCLES = 120000
) (
    input  logic              iCE_CLK,
    input  logic              reset_n,
    input  logic [NUM_IN-1:0] sw_raw,
    output logic [NUM_IN-1:0] sw_out,
    output logic [NUM_IN-1:0] sw_rise,
    output logic [NUM_IN-1:0] sw_fall
);

    // Counter only ever reaches STABLE_CYCLES-1, so clog2 bits are enough.
    localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } chan_state_e;

    logic [NUM_IN-1:0] sync_s1;
    logic [NUM_IN-1:0] sync_s2;

    // Two-flop synchronizer; only sync_s2 is used downstream.
    always_ff @(posedge iCE_CLK or negedge reset_n) begin
        if (!reset_n) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
        end else begin
            sync_s1 <= sw_raw;
            sync_s2 <= sync_s1;
        end
    end

    for (genvar g = 0; g < NUM_IN; g++) begin : g_chan
        chan_state_e      state_q;
        chan_state_e      state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             level_q;
        logic             level_d;
        logic             rise_q;
        logic             rise_d;
        logic             fall_q;
        logic             fall_d;
        logic             differs;

        // Synchronized input disagrees with the accepted level.
        assign differs = sync_s2[g] ^ level_q;

        // Channel state, counter, debounced level and pulse registers.
        always_ff @(posedge iCE_CLK or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= ST_STABLE;
                cnt_q   <= '0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        // Next-state: count while the input differs, drop to zero on any
        // agreement (no partial credit), accept on the final count.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            level_d = level_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            case (state_q)
                ST_STABLE: begin
                    if (differs) begin
                        state_d = ST_COUNTING;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d = '0;
                    end
                end
                ST_COUNTING: begin
                    if (!differs) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                        level_d = sync_s2[g];
                        rise_d  = sync_s2[g];
                        fall_d  = ~sync_s2[g];
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end
            endcase
        end

        assign sw_out[g]  = level_q;
        assign sw_rise[g] = rise_q;
        assign sw_fall[g] = fall_q;
    end

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce with STABLE_CYCLES=4: directed scenarios with
// hand-computed latencies plus randomized hold/bounce/reset traffic, all
// checked every cycle against a window-based reference model.
module tb_switch_debounce;

    localparam int NI = 3;
    localparam int SC = 4;

    logic          iCE_CLK = 1'b0;
    logic          reset_n = 1'b0;
    logic [NI-1:0] sw_raw  = '0;
    logic [NI-1:0] sw_out;
    logic [NI-1:0] sw_rise;
    logic [NI-1:0] sw_fall;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [NI-1:0] exp_out  = '0;
    logic [NI-1:0] exp_rise = '0;
    logic [NI-1:0] exp_fall = '0;
    logic [NI-1:0] raw_hist[$];
    logic [NI-1:0] s2_hist[$];

    int rise_tally[NI];
    int fall_tally[NI];

    switch_debounce #(
        .NUM_IN       (NI),
        .STABLE_CYCLES(SC)
    ) dut (
        .iCE_CLK(iCE_CLK),
        .reset_n(reset_n),
        .sw_raw (sw_raw),
        .sw_out (sw_out),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall)
    );

    always #5 iCE_CLK = ~iCE_CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    // Model: the synchronized value seen at edge n is the raw level captured
    // two edges earlier; a level is accepted when the last SC synchronized
    // samples all disagree with the current debounced level.
    initial begin
        for (int c = 0; c < NI; c++) begin
            rise_tally[c] = 0;
            fall_tally[c] = 0;
        end
        forever begin
            @(posedge iCE_CLK or negedge reset_n);
            if (!reset_n) begin
                exp_out  = '0;
                exp_rise = '0;
                exp_fall = '0;
                raw_hist.delete();
                s2_hist.delete();
            end else begin
                logic [NI-1:0] s2_seen;
                s2_seen = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : '0;
                raw_hist.push_back(sw_raw);
                if (raw_hist.size() > 2) void'(raw_hist.pop_front());
                s2_hist.push_back(s2_seen);
                if (s2_hist.size() > SC) void'(s2_hist.pop_front());
                exp_rise = '0;
                exp_fall = '0;
                if (s2_hist.size() == SC) begin
                    for (int c = 0; c < NI; c++) begin
                        bit all_differ;
                        all_differ = 1'b1;
                        for (int j = 0; j < SC; j++) begin
                            logic [NI-1:0] smp;
                            smp = s2_hist[j];
                            if (smp[c] == exp_out[c]) all_differ = 1'b0;
                        end
                        if (all_differ) begin
                            exp_out[c] = ~exp_out[c];
                            if (exp_out[c]) exp_rise[c] = 1'b1;
                            else            exp_fall[c] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, plus pulse tallies.
    always @(negedge iCE_CLK) begin
        check("sw_out",  32'(sw_out),  32'(exp_out));
        check("sw_rise", 32'(sw_rise), 32'(exp_rise));
        check("sw_fall", 32'(sw_fall), 32'(exp_fall));
        for (int c = 0; c < NI; c++) begin
            if (sw_rise[c]) rise_tally[c] = rise_tally[c] + 1;
            if (sw_fall[c]) fall_tally[c] = fall_tally[c] + 1;
        end
    end

    // First posedge after the call is the capture edge; counts the edges
    // from there until sw_out[ch] reaches lvl (bounded at 20).
    task automatic wait_out(input int ch, input logic lvl, output int n);
        @(posedge iCE_CLK);
        n = 0;
        while (n < 20) begin
            @(posedge iCE_CLK);
            n++;
            #1;
            if (sw_out[ch] == lvl) break;
        end
    endtask

    initial begin
        int n;
        int r_snap;
        int f_snap;
        logic [NI-1:0] v;
        int hold;
        int bounce[5];

        // Reset with all switches high
        sw_raw  = 3'b111;
        reset_n = 1'b0;
        repeat (3) @(posedge iCE_CLK);
        #1;
        check("rst_out",  32'(sw_out),  32'h0);
        check("rst_rise", 32'(sw_rise), 32'h0);
        check("rst_fall", 32'(sw_fall), 32'h0);
        @(negedge iCE_CLK);
        sw_raw  = 3'b000;
        reset_n = 1'b1;
        repeat (20) @(negedge iCE_CLK);
        #1;
        check("idle_out", 32'(sw_out), 32'h0);

        // Clean rise on bit 0
        @(negedge iCE_CLK);
        sw_raw = 3'b001;
        wait_out(0, 1'b1, n);
        check("rise_latency", 32'(n), 32'd5);
        check("rise_pulse",   32'(sw_rise), 32'h1);
        check("rise_nofall",  32'(sw_fall), 32'h0);
        @(posedge iCE_CLK);
        #1;
        check("rise_one_cycle", 32'(sw_rise), 32'h0);
        check("rise_level",     32'(sw_out),  32'h1);

        // Glitch on bit 1: 3 cycles rejected, then 4 cycles accepted
        @(negedge iCE_CLK);
        #1;
        r_snap = rise_tally[1];
        f_snap = fall_tally[1];
        sw_raw = 3'b011;
        repeat (3) @(negedge iCE_CLK);
        sw_raw = 3'b001;
        repeat (10) @(negedge iCE_CLK);
        #1;
        check("glitch_out",   32'(sw_out), 32'h1);
        check("glitch_rises", 32'(rise_tally[1] - r_snap), 32'd0);
        sw_raw = 3'b011;
        repeat (4) @(negedge iCE_CLK);
        sw_raw = 3'b001;
        repeat (12) @(negedge iCE_CLK);
        #1;
        check("held4_rises", 32'(rise_tally[1] - r_snap), 32'd1);
        check("held4_falls", 32'(fall_tally[1] - f_snap), 32'd1);

        // Bounce train on bit 2
        r_snap = rise_tally[2];
        bounce = '{1, 0, 1, 1, 0};
        for (int i = 0; i < 5; i++) begin
            @(negedge iCE_CLK);
            sw_raw[2] = 1'(bounce[i]);
        end
        @(negedge iCE_CLK);
        sw_raw[2] = 1'b1;
        wait_out(2, 1'b1, n);
        check("bounce_latency", 32'(n), 32'd5);
        repeat (3) @(negedge iCE_CLK);
        #1;
        check("bounce_rises", 32'(rise_tally[2] - r_snap), 32'd1);

        // Simultaneous fall/rise across channels
        @(negedge iCE_CLK);
        sw_raw = 3'b011;
        repeat (12) @(negedge iCE_CLK);
        #1;
        check("pre_simul_out", 32'(sw_out), 32'h3);
        @(negedge iCE_CLK);
        sw_raw = 3'b100;
        wait_out(2, 1'b1, n);
        check("simul_latency", 32'(n), 32'd5);
        check("simul_out",  32'(sw_out),  32'h4);
        check("simul_fall", 32'(sw_fall), 32'h3);
        check("simul_rise", 32'(sw_rise), 32'h4);

        // Reset while bit 0 is counting (cnt==2)
        @(negedge iCE_CLK);
        sw_raw = 3'b101;
        repeat (4) @(posedge iCE_CLK);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_out",  32'(sw_out),  32'h0);
        check("midrst_fall", 32'(sw_fall), 32'h0);
        check("midrst_rise", 32'(sw_rise), 32'h0);
        repeat (3) @(negedge iCE_CLK);
        reset_n = 1'b1;
        wait_out(0, 1'b1, n);
        check("midrst_latency", 32'(n), 32'd5);
        check("midrst_level",   32'(sw_out), 32'h5);

        // Randomized holds, bounces and occasional resets
        repeat (300) begin
            v    = NI'($urandom_range(0, 7));
            hold = int'($urandom_range(1, 8));
            @(negedge iCE_CLK);
            sw_raw = v;
            repeat (hold - 1) @(negedge iCE_CLK);
            if ($urandom_range(0, 49) == 0) begin
                #2;
                reset_n = 1'b0;
                repeat (2) @(negedge iCE_CLK);
                reset_n = 1'b1;
            end
        end

        repeat (10) @(negedge iCE_CLK);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
